// File: rtl/cam_capture_module.sv
// DVP camera capture: pairs 8-bit bytes into RGB565 pixels, skips the
// settling frames after reset, crops to the display window and writes
// the pixels into the CDC FIFO. All logic runs on the camera pixel clock.
module cam_capture_module #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter bit          VS_POL      = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow,
    output logic        capturing
);

    typedef enum logic [1:0] {StWaitSync, StSkip, StCapture} state_e;

    state_e      state_q, state_d;
    logic        vs_d1, hr_d1;
    logic [7:0]  skip_cnt_q;
    logic [10:0] col_q, row_q;
    logic        phase_q;
    logic [7:0]  high_q;

    logic        vs_start, vs_end, href_fall;
    logic        skip_last;
    logic        frame_begin, frame_end;
    logic        pix_formed, in_window;

    // Sync edge detection against the registered copies.
    assign vs_start  = (vs_d1 == VS_POL) && (cam_vsync != VS_POL);
    assign vs_end    = (vs_d1 != VS_POL) && (cam_vsync == VS_POL);
    assign href_fall = hr_d1 && !cam_href;
    // This vs_start completes the skip count.
    assign skip_last = ((32'(skip_cnt_q) + 32'd1) == SKIP_FRAMES);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StWaitSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: wait for the first sync, skip settling frames, then capture forever.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitSync: begin
                if (vs_start) begin
                    state_d = (SKIP_FRAMES == 0) ? StCapture : StSkip;
                end
            end
            StSkip: begin
                if (vs_start && skip_last) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StCapture;
            default:   state_d = StWaitSync;
        endcase
    end

    // State-derived decodes; the vs_start that enters CAPTURE also opens the first frame.
    always_comb begin
        capturing   = (state_q == StCapture);
        frame_begin = vs_start && (state_d == StCapture);
        frame_end   = vs_end && (state_q == StCapture);
        pix_formed  = (state_q == StCapture) && cam_href && phase_q;
        in_window   = (32'(col_q) < H_ACTIVE) && (32'(row_q) < V_ACTIVE);
    end

    // Sync delay registers and skip counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_d1      <= VS_POL;
            hr_d1      <= 1'b0;
            skip_cnt_q <= 8'd0;
        end else begin
            vs_d1 <= cam_vsync;
            hr_d1 <= cam_href;
            if ((state_q == StSkip) && vs_start && (skip_cnt_q != 8'hFF)) begin
                skip_cnt_q <= skip_cnt_q + 8'd1;
            end
        end
    end

    // Byte pairing: phase 0 holds the high byte; an odd trailing byte is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= 1'b0;
            high_q  <= 8'd0;
        end else begin
            if (capturing && cam_href && !frame_begin) begin
                phase_q <= ~phase_q;
            end else begin
                phase_q <= 1'b0;
            end
            if (capturing && cam_href && !phase_q) begin
                high_q <= cam_data;
            end
        end
    end

    // Column/row position within the frame, both saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_q <= 11'd0;
            row_q <= 11'd0;
        end else if (frame_begin) begin
            col_q <= 11'd0;
            row_q <= 11'd0;
        end else if (capturing) begin
            if (href_fall) begin
                if ((col_q != 11'd0) && (row_q != 11'h7FF)) begin
                    row_q <= row_q + 11'd1;
                end
                col_q <= 11'd0;
            end else if (pix_formed && (col_q != 11'h7FF)) begin
                col_q <= col_q + 11'd1;
            end
        end
    end

    // FIFO write, frame pulses and sticky overflow, all one cycle after the decision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 16'd0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_start <= frame_begin;
            frame_done  <= frame_end;
            fifo_wr_en  <= pix_formed && in_window && !fifo_full;
            if (pix_formed && in_window && !fifo_full) begin
                fifo_wr_data <= {high_q, cam_data};
            end
            if (pix_formed && in_window && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_module.sv
// Bench for cam_capture_module: random DVP frames against a pixel-list model.
module tb_cam_capture_module;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 4;
    localparam int unsigned SKIP = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cam_vsync, cam_href, fifo_full;
    logic [7:0]  cam_data;
    logic        fifo_wr_en, frame_start, frame_done, overflow, capturing;
    logic [15:0] fifo_wr_data;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] act_q[$];
    logic [15:0] exp_q[$];
    int          fs_cnt = 0;
    int          fd_cnt = 0;
    int          vs_since_rst;
    bit          exp_ovf;
    int          line_len[8];
    int          n_lines;

    always #5 CLK = ~CLK;

    cam_capture_module #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .SKIP_FRAMES(SKIP),
        .VS_POL     (1'b1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .capturing   (capturing)
    );

    // Monitor: collect writes and frame pulses away from the active edge.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (fifo_wr_en === 1'b1) act_q.push_back(fifo_wr_data);
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One frame: vsync leaves blanking, n_lines lines of random bytes, back to blanking.
    // The model lists the pixels the frame must produce: pairs of bytes per line, the
    // first H pixels of the first V non-empty lines, minus those offered while full.
    task automatic send_frame(input int full_line, input int full_pix, input int full_pct,
                              output bit cap_seen);
        bit         cap;
        bit         full;
        int         r;
        logic [7:0] b, prev;
        cam_vsync = 1'b0;
        vs_since_rst++;
        cap = (vs_since_rst >= int'(SKIP) + 1);
        tick();
        cap_seen = capturing;
        tick();
        r = 0;
        prev = 8'd0;
        for (int l = 0; l < n_lines; l++) begin
            for (int i = 0; i < line_len[l]; i++) begin
                b = 8'($urandom);
                full = (l == full_line && i == 2 * full_pix + 1) ||
                       (int'($urandom_range(99)) < full_pct);
                cam_href  = 1'b1;
                cam_data  = b;
                fifo_full = full;
                if (i % 2 == 1 && cap && i / 2 < int'(H) && r < int'(V)) begin
                    if (full) exp_ovf = 1'b1;
                    else exp_q.push_back({prev, b});
                end
                prev = b;
                tick();
            end
            cam_href  = 1'b0;
            cam_data  = 8'd0;
            fifo_full = 1'b0;
            if (line_len[l] >= 2) r++;
            repeat (2 + $urandom_range(2)) tick();
        end
        cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'd0; fifo_full = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({fifo_wr_en, frame_start, frame_done, overflow, capturing, fifo_wr_data} !== 21'd0)
        begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%h want all 0", fifo_wr_en,
                     frame_start, frame_done, overflow, capturing, fifo_wr_data);
        end
        RST = 1'b0;
        vs_since_rst = 0;
        exp_ovf = 1'b0;
        tick();
    endtask

    task automatic test_skip_and_capture();
        bit c1, c2, c3;
        int base, fs0, fd0;
        exp_q.delete();
        base = act_q.size(); fs0 = fs_cnt; fd0 = fd_cnt;
        n_lines = 4;
        for (int l = 0; l < 4; l++) line_len[l] = 8;
        send_frame(-1, -1, 0, c1);
        send_frame(-1, -1, 0, c2);
        n_vec++;
        if (act_q.size() - base !== 0) begin
            n_err++; $display("FAIL skip_no_writes: got %0d want 0", act_q.size() - base);
        end
        n_vec++;
        if ({c1, c2} !== 2'b00) begin
            n_err++; $display("FAIL skip_capturing: got %b%b want 00", c1, c2);
        end
        send_frame(-1, -1, 0, c3);
        n_vec++;
        if (c3 !== 1'b1) begin
            n_err++; $display("FAIL capture_rise: got %b want 1", c3);
        end
        n_vec++;
        if (act_q.size() - base !== 16) begin
            n_err++; $display("FAIL capture_count: got %0d want 16", act_q.size() - base);
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL capture_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
        n_vec++;
        if (fs_cnt - fs0 !== 1 || fd_cnt - fd0 !== 1) begin
            n_err++;
            $display("FAIL capture_pulses: got %0d/%0d want 1/1", fs_cnt - fs0, fd_cnt - fd0);
        end
    endtask

    task automatic test_pixel_latency();
        int base, fs0, fd0;
        base = act_q.size(); fs0 = fs_cnt; fd0 = fd_cnt;
        cam_vsync = 1'b0; vs_since_rst++;
        tick(); tick();
        cam_href = 1'b1; cam_data = 8'hF8;
        tick();
        cam_data = 8'h1F;
        n_vec++;
        if (fifo_wr_en !== 1'b0) begin
            n_err++; $display("FAIL latency_early: got wr_en %b want 0", fifo_wr_en);
        end
        tick();
        cam_href = 1'b0; cam_data = 8'd0;
        n_vec++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'hF81F) begin
            n_err++;
            $display("FAIL latency_write: got %b/%h want 1/f81f", fifo_wr_en, fifo_wr_data);
        end
        tick();
        n_vec++;
        if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 16'hF81F) begin
            n_err++;
            $display("FAIL latency_hold: got %b/%h want 0/f81f", fifo_wr_en, fifo_wr_data);
        end
        tick(); tick();
        cam_vsync = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (act_q.size() - base !== 1 || fs_cnt - fs0 !== 1 || fd_cnt - fd0 !== 1) begin
            n_err++;
            $display("FAIL latency_frame: got %0d writes %0d/%0d pulses want 1 and 1/1",
                     act_q.size() - base, fs_cnt - fs0, fd_cnt - fd0);
        end
    endtask

    task automatic test_crop();
        bit c;
        int base;
        exp_q.delete();
        base = act_q.size();
        n_lines = 6;
        for (int l = 0; l < 6; l++) line_len[l] = 10;
        send_frame(-1, -1, 0, c);
        n_vec++;
        if (act_q.size() - base !== 16) begin
            n_err++; $display("FAIL crop_count: got %0d want 16", act_q.size() - base);
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL crop_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
    endtask

    task automatic test_odd_byte();
        bit c;
        int base;
        exp_q.delete();
        base = act_q.size();
        n_lines = 2; line_len[0] = 7; line_len[1] = 8;
        send_frame(-1, -1, 0, c);
        n_vec++;
        if (act_q.size() - base !== 7) begin
            n_err++; $display("FAIL odd_count: got %0d want 7", act_q.size() - base);
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL odd_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
    endtask

    task automatic test_overflow();
        bit c;
        int base;
        exp_q.delete();
        base = act_q.size();
        n_lines = 4;
        for (int l = 0; l < 4; l++) line_len[l] = 8;
        send_frame(0, 1, 0, c);
        n_vec++;
        if (act_q.size() - base !== 15 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drop: got %0d writes ovf %b want 15 ovf 1",
                     act_q.size() - base, overflow);
        end
        send_frame(-1, -1, 0, c);
        n_vec++;
        if (act_q.size() - base !== 31 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %0d writes ovf %b want 31 ovf 1",
                     act_q.size() - base, overflow);
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL ovf_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        bit c;
        int base, fs0, fd0;
        exp_q.delete();
        base = act_q.size(); fs0 = fs_cnt; fd0 = fd_cnt;
        for (int f = 0; f < 5; f++) begin
            n_lines = 1 + $urandom_range(5);
            for (int l = 0; l < n_lines; l++) line_len[l] = 1 + $urandom_range(11);
            send_frame(-1, -1, 15, c);
        end
        n_vec++;
        if (act_q.size() - base !== exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d want %0d", act_q.size() - base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL rand_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
        n_vec++;
        if (overflow !== exp_ovf || fs_cnt - fs0 !== 5 || fd_cnt - fd0 !== 5) begin
            n_err++;
            $display("FAIL rand_status: got ovf %b pulses %0d/%0d want ovf %b pulses 5/5",
                     overflow, fs_cnt - fs0, fd_cnt - fd0, exp_ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit c1, c2, c3;
        int base;
        cam_vsync = 1'b0;
        tick(); tick();
        cam_href = 1'b1; cam_data = 8'($urandom);
        tick();
        cam_data = 8'($urandom); RST = 1'b1;
        tick();
        n_vec++;
        if ({fifo_wr_en, frame_start, frame_done, overflow, capturing, fifo_wr_data} !== 21'd0)
        begin
            n_err++;
            $display("FAIL midreset_outputs: got %b/%b/%b/%b/%b/%h want all 0", fifo_wr_en,
                     frame_start, frame_done, overflow, capturing, fifo_wr_data);
        end
        cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'd0;
        tick();
        RST = 1'b0; vs_since_rst = 0; exp_ovf = 1'b0;
        tick();
        exp_q.delete();
        base = act_q.size();
        n_lines = 4;
        for (int l = 0; l < 4; l++) line_len[l] = 8;
        send_frame(-1, -1, 0, c1);
        send_frame(-1, -1, 0, c2);
        n_vec++;
        if ({c1, c2} !== 2'b00 || act_q.size() - base !== 0) begin
            n_err++;
            $display("FAIL midreset_skip: got cap %b%b writes %0d want 00 and 0", c1, c2,
                     act_q.size() - base);
        end
        send_frame(-1, -1, 0, c3);
        n_vec++;
        if (c3 !== 1'b1 || act_q.size() - base !== 16 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_resume: got cap %b writes %0d ovf %b want 1, 16, 0", c3,
                     act_q.size() - base, overflow);
        end
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++) begin
            n_vec++;
            if (act_q[base + k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL midreset_data[%0d]: got %h want %h", k, act_q[base + k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_skip_and_capture();
        test_pixel_latency();
        test_crop();
        test_odd_byte();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cam_capture_module.md
Name: cam_capture_module

Overview:
- Writer-side counterpart to the display path: captures an 8-bit DVP camera byte stream (VSYNC/HREF/DATA) and packs byte pairs into RGB565 pixels.
- Writes the pixels into the line/frame FIFO that the VGA control path drains.
- Handles the camera settling frames, crops to the display window and flags FIFO overflow.
- Runs in the camera pixel-clock domain; the FIFO provides the clock-domain crossing.

Parameters:
- H_ACTIVE, 800, pixels per line written to the FIFO; pixels beyond this are cropped.
- V_ACTIVE, 480, lines per frame written to the FIFO; lines beyond this are cropped.
- SKIP_FRAMES, 10, whole frames discarded after reset before capture begins (range 0..255).
- VS_POL, 1, VSYNC level during vertical blanking (1 = active-high).

Ports:
- CLK  in  1  camera pixel clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera VSYNC.
- cam_href  in  1  camera HREF; 1 = valid byte on cam_data.
- cam_data  in  8  camera byte; high byte of the pixel first.
- fifo_full  in  1  FIFO full flag, same clock.
- fifo_wr_en  out  1  FIFO write strobe, one cycle per pixel.
- fifo_wr_data  out  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- frame_start  out  1  one-cycle pulse when a captured frame begins.
- frame_done  out  1  one-cycle pulse when a captured frame ends.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- capturing  out  1  high while in state CAPTURE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is WAIT_SYNC. Skip counter, column counter, row counter and byte phase are 0.
  - The vsync/href delay registers are loaded with the blanking level (VS_POL, 0).
  - Reset mid-frame abandons the frame with no partial write; the pixel in flight is discarded.
- Edge detection:
  - cam_vsync and cam_href are registered once (vs_d1, hr_d1).
  - vs_start = (vs_d1 == VS_POL) && (cam_vsync != VS_POL), i.e. leaving blanking.
  - vs_end = the opposite transition.
  - href_fall = hr_d1 && !cam_href.
- State machine:
  - WAIT_SYNC -> SKIP on the first vs_start.
  - SKIP: each vs_start increments the skip counter. Once the counter equals SKIP_FRAMES, that same vs_start moves to CAPTURE. With SKIP_FRAMES = 0, the first vs_start goes WAIT_SYNC -> CAPTURE directly.
  - CAPTURE: on vs_start, clear column, row and phase, and assert frame_start on the next cycle. On vs_end, assert frame_done on the next cycle. Stay in CAPTURE from then on; each following vs_start begins a new frame.
  - A vs_start arriving before vs_end (truncated frame) restarts the counters; frame_done is not pulsed for the truncated frame.
- Byte pairing (CAPTURE only, cam_href = 1):
  - Phase 0: latch cam_data as the high byte.
  - Phase 1: form pixel = {high, cam_data}. The phase toggles every byte.
  - Phase is forced to 0 whenever cam_href = 0, so an odd trailing byte is discarded.
- Write:
  - Pixel formed in cycle N -> fifo_wr_en = 1 with fifo_wr_data valid in cycle N+1 (one-cycle latency).
  - A write occurs only if col < H_ACTIVE, row < V_ACTIVE and fifo_full = 0, with fifo_full sampled in the cycle the pixel is formed.
  - fifo_wr_data holds its last value when fifo_wr_en = 0.
- Counters:
  - The column counter (11 bits) increments per formed pixel, saturating at 2047.
  - On href_fall: if the column counter is nonzero, row increments (saturating at 2047); the column counter then clears.
- Overflow:
  - A formed, in-window pixel with fifo_full = 1 is dropped and sets overflow.
  - overflow clears only on RST. Capture continues after an overflow.
- Outside CAPTURE: fifo_wr_en is never asserted.

Test Plan:
- SKIP_FRAMES=2, 3 frames of 4 lines x 8 bytes, H_ACTIVE=4, V_ACTIVE=4 -> no writes in frames 1-2; frame 3 gives 16 writes; frame_start and frame_done each pulse once; capturing rises on the 3rd vs_start.
- Bytes 0xF8, 0x1F in one line -> fifo_wr_data=0xF81F with fifo_wr_en high exactly one cycle after the 0x1F sample.
- Line of 10 bytes with H_ACTIVE=4 -> 4 writes, the 5th pixel is cropped; 6 lines with V_ACTIVE=4 -> 16 writes total.
- Line of 7 bytes -> 3 writes; the 7th byte is discarded; the next line's first pixel pairs correctly.
- fifo_full=1 during the 2nd pixel of a line -> that pixel is not written, overflow=1 and stays 1 across the following frame; other pixels are written.
- RST asserted mid-line during CAPTURE -> outputs 0 the next cycle; after release, capture resumes only after SKIP_FRAMES+1 vs_start edges.
